// File: rtl/load_store_unit.sv
// ============================================================================
//  Module      : load_store_unit
//  Description : Memory stage behind the execute ALU. Passes ALU results
//                through, or performs byte/half/word loads and stores over a
//                req/gnt/rvalid data-memory port with lane alignment,
//                sign/zero extension and misalignment detection. Retires
//                every operation with a single-cycle writeback pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_store_unit #(
  parameter int REG_WIDTH = 32,
  parameter int RD_WIDTH  = 5
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [1:0]           i_mem_op,
  input  logic [1:0]           i_size,
  input  logic                 i_unsigned,
  input  logic [REG_WIDTH-1:0] i_addr,
  input  logic [REG_WIDTH-1:0] i_store_data,
  input  logic [RD_WIDTH-1:0]  i_rd,
  output logic                 o_mem_req,
  output logic                 o_mem_we,
  output logic [REG_WIDTH-1:0] o_mem_addr,
  output logic [REG_WIDTH-1:0] o_mem_wdata,
  output logic [3:0]           o_mem_wstrb,
  input  logic                 i_mem_gnt,
  input  logic                 i_mem_rvalid,
  input  logic [REG_WIDTH-1:0] i_mem_rdata,
  output logic                 o_wb_valid,
  output logic                 o_wb_we,
  output logic [REG_WIDTH-1:0] o_wb_data,
  output logic [RD_WIDTH-1:0]  o_wb_rd,
  output logic                 o_misaligned
);

  // FSM encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  // Normalised access size held for the in-flight operation
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  logic [1:0] state;
  logic [1:0] state_next;

  // Decoded view of the operation presented by execute
  logic       accept;
  logic       op_load;
  logic       op_store;
  logic       size_half;
  logic       size_word;
  logic       misalign;
  logic       start_mem;
  logic [1:0] size_norm;

  // Operation fields captured at acceptance
  logic                 is_load_q;
  logic [1:0]           size_q;
  logic                 unsigned_q;
  logic [1:0]           offset_q;
  logic [REG_WIDTH-1:0] word_addr_q;
  logic [REG_WIDTH-1:0] wdata_q;
  logic [3:0]           wstrb_q;
  logic [RD_WIDTH-1:0]  rd_q;

  // Store lane placement for the incoming operation
  logic [REG_WIDTH-1:0] lane_wdata;
  logic [3:0]           lane_wstrb;

  // Load data after lane shift and extension
  logic [REG_WIDTH-1:0] load_shifted;
  logic [REG_WIDTH-1:0] load_ext;

  // Writeback registers
  logic                 wb_valid_q;
  logic                 wb_we_q;
  logic [REG_WIDTH-1:0] wb_data_q;
  logic [RD_WIDTH-1:0]  wb_rd_q;
  logic                 misaligned_q;

  // Reserved mem_op decodes as pass-through, reserved size as word
  always_comb begin
    accept    = i_valid && (state == ST_IDLE);
    op_load   = (i_mem_op == 2'd1);
    op_store  = (i_mem_op == 2'd2);
    size_half = (i_size == 2'd1);
    size_word = i_size[1];
    misalign  = (op_load || op_store) &&
                ((size_half && i_addr[0]) || (size_word && (i_addr[1:0] != 2'b00)));
    start_mem = accept && (op_load || op_store) && !misalign;
    if (size_word)      size_norm = SZ_WORD;
    else if (size_half) size_norm = SZ_HALF;
    else                size_norm = SZ_BYTE;
  end

  // Replicate store data across lanes and pick the byte enables; loads drive zeros
  always_comb begin
    lane_wdata = '0;
    lane_wstrb = 4'b0000;
    if (op_store) begin
      case (size_norm)
        SZ_BYTE: begin
          lane_wdata = {4{i_store_data[7:0]}};
          lane_wstrb = 4'b0001 << i_addr[1:0];
        end
        SZ_HALF: begin
          lane_wdata = {2{i_store_data[15:0]}};
          lane_wstrb = 4'b0011 << i_addr[1:0];
        end
        default: begin
          lane_wdata = i_store_data;
          lane_wstrb = 4'b1111;
        end
      endcase
    end
  end

  // Shift the returned word down to the addressed lane and extend it
  always_comb begin
    load_shifted = i_mem_rdata >> {offset_q, 3'b000};
    case (size_q)
      SZ_BYTE: load_ext = {{(REG_WIDTH-8){!unsigned_q && load_shifted[7]}},
                           load_shifted[7:0]};
      SZ_HALF: load_ext = {{(REG_WIDTH-16){!unsigned_q && load_shifted[15]}},
                           load_shifted[15:0]};
      default: load_ext = load_shifted;
    endcase
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next-state logic: rvalid only counts once we are in WAIT
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start_mem)    state_next = ST_REQ;
      ST_REQ:  if (i_mem_gnt)    state_next = is_load_q ? ST_WAIT : ST_IDLE;
      ST_WAIT: if (i_mem_rvalid) state_next = ST_IDLE;
      default:                   state_next = ST_IDLE;
    endcase
  end

  // Output logic: memory port signals are only non-zero while requesting
  always_comb begin
    o_ready     = (state == ST_IDLE);
    o_mem_req   = (state == ST_REQ);
    o_mem_we    = (state == ST_REQ) && !is_load_q;
    o_mem_addr  = (state == ST_REQ) ? word_addr_q : '0;
    o_mem_wdata = (state == ST_REQ) ? wdata_q : '0;
    o_mem_wstrb = (state == ST_REQ) ? wstrb_q : 4'b0000;
  end

  // Capture operation fields on acceptance; they stay stable until the grant
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      is_load_q   <= 1'b0;
      size_q      <= SZ_BYTE;
      unsigned_q  <= 1'b0;
      offset_q    <= 2'b00;
      word_addr_q <= '0;
      wdata_q     <= '0;
      wstrb_q     <= 4'b0000;
      rd_q        <= '0;
    end else if (start_mem) begin
      is_load_q   <= op_load;
      size_q      <= size_norm;
      unsigned_q  <= i_unsigned;
      offset_q    <= i_addr[1:0];
      word_addr_q <= {i_addr[REG_WIDTH-1:2], 2'b00};
      wdata_q     <= lane_wdata;
      wstrb_q     <= lane_wstrb;
      rd_q        <= i_rd;
    end
  end

  // Writeback: one-cycle retire pulse for pass-through, misaligned, store grant and load data
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wb_valid_q   <= 1'b0;
      wb_we_q      <= 1'b0;
      wb_data_q    <= '0;
      wb_rd_q      <= '0;
      misaligned_q <= 1'b0;
    end else begin
      wb_valid_q   <= 1'b0;
      misaligned_q <= 1'b0;
      if (accept && !start_mem) begin
        wb_valid_q <= 1'b1;
        wb_rd_q    <= i_rd;
        if (misalign) begin
          misaligned_q <= 1'b1;
          wb_we_q      <= 1'b0;
          wb_data_q    <= '0;
        end else begin
          wb_we_q   <= (i_rd != '0);
          wb_data_q <= i_addr;
        end
      end else if ((state == ST_REQ) && i_mem_gnt && !is_load_q) begin
        wb_valid_q <= 1'b1;
        wb_we_q    <= 1'b0;
        wb_data_q  <= '0;
        wb_rd_q    <= rd_q;
      end else if ((state == ST_WAIT) && i_mem_rvalid) begin
        wb_valid_q <= 1'b1;
        wb_we_q    <= (rd_q != '0);
        wb_data_q  <= load_ext;
        wb_rd_q    <= rd_q;
      end
    end
  end

  assign o_wb_valid   = wb_valid_q;
  assign o_wb_we      = wb_we_q;
  assign o_wb_data    = wb_data_q;
  assign o_wb_rd      = wb_rd_q;
  assign o_misaligned = misaligned_q;

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// ============================================================================
//  Module      : tb_load_store_unit
//  Description : Directed self-checking bench for load_store_unit.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_load_store_unit;

  logic        clk;
  logic        rst;
  logic        valid;
  logic        ready;
  logic [1:0]  mem_op;
  logic [1:0]  size;
  logic        uns;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic [4:0]  rd;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        wb_valid;
  logic        wb_we;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        misaligned;

  int checks = 0;
  int errors = 0;

  load_store_unit #(.REG_WIDTH(32), .RD_WIDTH(5)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_valid      (valid),
    .o_ready      (ready),
    .i_mem_op     (mem_op),
    .i_size       (size),
    .i_unsigned   (uns),
    .i_addr       (addr),
    .i_store_data (store_data),
    .i_rd         (rd),
    .o_mem_req    (mem_req),
    .o_mem_we     (mem_we),
    .o_mem_addr   (mem_addr),
    .o_mem_wdata  (mem_wdata),
    .o_mem_wstrb  (mem_wstrb),
    .i_mem_gnt    (mem_gnt),
    .i_mem_rvalid (mem_rvalid),
    .i_mem_rdata  (mem_rdata),
    .o_wb_valid   (wb_valid),
    .o_wb_we      (wb_we),
    .o_wb_data    (wb_data),
    .o_wb_rd      (wb_rd),
    .o_misaligned (misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [1:0] op, input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] d, input logic [4:0] r);
    valid      = 1'b1;
    mem_op     = op;
    size       = sz;
    uns        = u;
    addr       = a;
    store_data = d;
    rd         = r;
  endtask

  // Aligned load with gnt on the first REQ cycle, rvalid two cycles after gnt.
  // A bogus rvalid is driven during the gnt cycle and must be ignored.
  task automatic do_load(input string tag, input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [4:0] r,
                         input logic [31:0] rdata, input logic [31:0] exp_data);
    present(2'd1, sz, u, a, 32'h0, r);
    tick();
    valid = 1'b0;
    check({tag, "_req"},   {31'h0, mem_req}, 32'h1);
    check({tag, "_addr"},  mem_addr, {a[31:2], 2'b00});
    check({tag, "_we"},    {31'h0, mem_we}, 32'h0);
    check({tag, "_wstrb"}, {28'h0, mem_wstrb}, 32'h0);
    mem_gnt    = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hDEAD_BEEF;
    tick();
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    check({tag, "_req_drop"}, {31'h0, mem_req}, 32'h0);
    check({tag, "_no_early"}, {31'h0, wb_valid}, 32'h0);
    tick();
    check({tag, "_wait"}, {31'h0, wb_valid}, 32'h0);
    mem_rvalid = 1'b1;
    mem_rdata  = rdata;
    tick();
    mem_rvalid = 1'b0;
    check({tag, "_wbv"},  {31'h0, wb_valid}, 32'h1);
    check({tag, "_data"}, wb_data, exp_data);
    check({tag, "_wbwe"}, {31'h0, wb_we}, {31'h0, (r != 5'd0)});
    check({tag, "_rd"},   {27'h0, wb_rd}, {27'h0, r});
    check({tag, "_mis"},  {31'h0, misaligned}, 32'h0);
  endtask

  task automatic do_misaligned(input string tag, input logic [1:0] op, input logic [1:0] sz,
                               input logic [31:0] a);
    present(op, sz, 1'b0, a, 32'h1111_2222, 5'd6);
    tick();
    valid = 1'b0;
    check({tag, "_wbv"},   {31'h0, wb_valid}, 32'h1);
    check({tag, "_mis"},   {31'h0, misaligned}, 32'h1);
    check({tag, "_wbwe"},  {31'h0, wb_we}, 32'h0);
    check({tag, "_data"},  wb_data, 32'h0);
    check({tag, "_req"},   {31'h0, mem_req}, 32'h0);
    check({tag, "_ready"}, {31'h0, ready}, 32'h1);
    tick();
    check({tag, "_pulse"}, {31'h0, wb_valid}, 32'h0);
  endtask

  // Store with gnt after a given number of low cycles
  task automatic do_store(input string tag, input logic [1:0] sz, input logic [31:0] a,
                          input logic [31:0] d, input int gnt_delay,
                          input logic [31:0] exp_wdata, input logic [3:0] exp_wstrb);
    present(2'd2, sz, 1'b0, a, d, 5'd9);
    tick();
    valid = 1'b0;
    for (int i = 0; i <= gnt_delay; i++) begin
      if (i == gnt_delay) mem_gnt = 1'b1;
      check({tag, "_req"},   {31'h0, mem_req}, 32'h1);
      check({tag, "_we"},    {31'h0, mem_we}, 32'h1);
      check({tag, "_addr"},  mem_addr, {a[31:2], 2'b00});
      check({tag, "_wdata"}, mem_wdata, exp_wdata);
      check({tag, "_wstrb"}, {28'h0, mem_wstrb}, {28'h0, exp_wstrb});
      check({tag, "_nowb"},  {31'h0, wb_valid}, 32'h0);
      tick();
    end
    mem_gnt = 1'b0;
    check({tag, "_wbv"},   {31'h0, wb_valid}, 32'h1);
    check({tag, "_wbwe"},  {31'h0, wb_we}, 32'h0);
    check({tag, "_mis"},   {31'h0, misaligned}, 32'h0);
    check({tag, "_req0"},  {31'h0, mem_req}, 32'h0);
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; mem_op = 2'd0; size = 2'd0; uns = 1'b0;
    addr = 32'h0; store_data = 32'h0; rd = 5'd0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("rst_ready", {31'h0, ready}, 32'h1);
    check("rst_req",   {31'h0, mem_req}, 32'h0);
    check("rst_wbv",   {31'h0, wb_valid}, 32'h0);
    check("rst_mis",   {31'h0, misaligned}, 32'h0);
    check("rst_wstrb", {28'h0, mem_wstrb}, 32'h0);

    // Pass-through
    present(2'd0, 2'd2, 1'b0, 32'h1234_5678, 32'h0, 5'd7);
    tick();
    valid = 1'b0;
    check("none_wbv",  {31'h0, wb_valid}, 32'h1);
    check("none_we",   {31'h0, wb_we}, 32'h1);
    check("none_data", wb_data, 32'h1234_5678);
    check("none_rd",   {27'h0, wb_rd}, 32'd7);
    check("none_req",  {31'h0, mem_req}, 32'h0);
    tick();
    check("none_pulse", {31'h0, wb_valid}, 32'h0);

    // Reserved mem_op with rd=0: pass-through, no register write
    present(2'd3, 2'd0, 1'b0, 32'h0000_00FF, 32'h0, 5'd0);
    tick();
    valid = 1'b0;
    check("rsv_wbv",  {31'h0, wb_valid}, 32'h1);
    check("rsv_we",   {31'h0, wb_we}, 32'h0);
    check("rsv_data", wb_data, 32'h0000_00FF);
    tick();

    // Stores
    do_store("st_b", 2'd0, 32'h0000_0103, 32'h0000_00A5, 2, 32'hA5A5_A5A5, 4'b1000);
    do_store("st_h", 2'd1, 32'h0000_0102, 32'h1234_BEEF, 0, 32'hBEEF_BEEF, 4'b1100);
    do_store("st_w", 2'd3, 32'h0000_0400, 32'hCAFE_BABE, 1, 32'hCAFE_BABE, 4'b1111);

    // Loads
    do_load("ld_hs", 2'd1, 1'b0, 32'h0000_0202, 5'd3, 32'h8001_1234, 32'hFFFF_8001);
    do_load("ld_hu", 2'd1, 1'b1, 32'h0000_0202, 5'd3, 32'h8001_1234, 32'h0000_8001);
    do_load("ld_bu", 2'd0, 1'b1, 32'h0000_0201, 5'd4, 32'h8001_1234, 32'h0000_0012);
    do_load("ld_bs", 2'd0, 1'b0, 32'h0000_0203, 5'd5, 32'h8001_1234, 32'hFFFF_FF80);
    do_load("ld_w0", 2'd2, 1'b0, 32'h0000_0200, 5'd0, 32'h8001_1234, 32'h8001_1234);

    // Misaligned accesses
    do_misaligned("mis_lw", 2'd1, 2'd2, 32'h0000_0006);
    do_misaligned("mis_lh", 2'd1, 2'd1, 32'h0000_0003);
    do_misaligned("mis_sw", 2'd2, 2'd3, 32'h0000_0001);

    // Reset while waiting for read data; stale rvalid afterwards
    present(2'd1, 2'd2, 1'b0, 32'h0000_0300, 32'h0, 5'd8);
    tick();
    valid   = 1'b0;
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    rst     = 1'b1;
    tick();
    rst        = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h5555_AAAA;
    check("rw_ready", {31'h0, ready}, 32'h1);
    check("rw_req",   {31'h0, mem_req}, 32'h0);
    check("rw_wbv",   {31'h0, wb_valid}, 32'h0);
    tick();
    mem_rvalid = 1'b0;
    check("rw_stale_wbv", {31'h0, wb_valid}, 32'h0);
    check("rw_stale_rdy", {31'h0, ready}, 32'h1);
    tick();
    check("rw_stale_wbv2", {31'h0, wb_valid}, 32'h0);

    // Back-to-back: pass-through accepted in the store retire cycle
    present(2'd2, 2'd2, 1'b0, 32'h0000_0500, 32'h1357_9BDF, 5'd9);
    tick();
    valid   = 1'b0;
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    check("b2b_st_wbv", {31'h0, wb_valid}, 32'h1);
    check("b2b_st_we",  {31'h0, wb_we}, 32'h0);
    check("b2b_st_mis", {31'h0, misaligned}, 32'h0);
    check("b2b_ready",  {31'h0, ready}, 32'h1);
    present(2'd0, 2'd0, 1'b0, 32'h0000_0055, 32'h0, 5'd4);
    tick();
    valid = 1'b0;
    check("b2b_n_wbv",  {31'h0, wb_valid}, 32'h1);
    check("b2b_n_data", wb_data, 32'h0000_0055);
    check("b2b_n_we",   {31'h0, wb_we}, 32'h1);
    check("b2b_n_rd",   {27'h0, wb_rd}, 32'd4);
    check("b2b_n_req",  {31'h0, mem_req}, 32'h0);
    tick();
    check("b2b_end", {31'h0, wb_valid}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
